led_shift_out: RTL

Serializer stage downstream of the LED counter: consumes the counter's 8-bit LED value and shifts it MSB-first into an external 74HC595-style shift register (data, shift clock, latch strobe). A new frame is sent whenever the LED value differs from the last value sent, and always once after reset. While a frame is in flight, input changes are ignored. After each frame the current input is re-compared, so intermediate values are dropped and the newest value is always the one sent.

---
 rtl/led_shift_out.sv | 136 +++++++++++++
 1 files changed

// File: rtl/led_shift_out.sv
// Serialises the 8-bit LED value MSB-first into a 74HC595-style shift register.
// A frame is sent after reset and whenever LED differs from the last value sent.
module led_shift_out #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       CLK,
   input  logic       RSTN,
   input  logic [7:0] LED,
   output logic       SER_DATA,
   output logic       SER_CLK,
   output logic       SER_LATCH,
   output logic       BUSY
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2
   } state_e;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   state_e     state_q, state_d;
   logic [7:0] div_q,   div_d;
   logic [2:0] bit_q,   bit_d;
   logic [7:0] shreg_q, shreg_d;
   logic [7:0] last_q,  last_d;
   logic       init_q,  init_d;
   logic       data_q,  data_d;
   logic       sclk_q,  sclk_d;
   logic       latch_q, latch_d;
   logic       busy_q,  busy_d;
   logic       div_end;

   assign div_end = (div_q == DIV_LAST);

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      last_d  = last_q;
      init_d  = init_q;
      data_d  = data_q;
      sclk_d  = sclk_q;
      latch_d = latch_q;
      busy_d  = busy_q;

      case (state_q)
         IDLE: begin
            if ((LED != last_q) || init_q) begin
               shreg_d = LED;
               last_d  = LED;
               init_d  = 1'b0;
               data_d  = LED[7];
               busy_d  = 1'b1;
               sclk_d  = 1'b0;
               div_d   = 8'd0;
               bit_d   = 3'd0;
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            if (!div_end) begin
               div_d = div_q + 8'd1;
            end else begin
               div_d = 8'd0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else begin
                  sclk_d = 1'b0;
                  if (bit_q == 3'd7) begin
                     data_d  = 1'b0;
                     latch_d = 1'b1;
                     state_d = LATCH;
                  end else begin
                     // Rotate so the next bit lands in the MSB that SER_DATA follows.
                     shreg_d = {shreg_q[6:0], shreg_q[7]};
                     data_d  = shreg_q[6];
                     bit_d   = bit_q + 3'd1;
                  end
               end
            end
         end

         LATCH: begin
            if (!div_end) begin
               div_d = div_q + 8'd1;
            end else begin
               div_d   = 8'd0;
               latch_d = 1'b0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Reset mid-frame abandons the frame and forces a resend of the current LED.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= IDLE;
         div_q   <= 8'd0;
         bit_q   <= 3'd0;
         shreg_q <= 8'h00;
         last_q  <= 8'h00;
         init_q  <= 1'b1;
         data_q  <= 1'b0;
         sclk_q  <= 1'b0;
         latch_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         last_q  <= last_d;
         init_q  <= init_d;
         data_q  <= data_d;
         sclk_q  <= sclk_d;
         latch_q <= latch_d;
         busy_q  <= busy_d;
      end
   end

   assign SER_DATA  = data_q;
   assign SER_CLK   = sclk_q;
   assign SER_LATCH = latch_q;
   assign BUSY      = busy_q;

endmodule
